// File: rtl/cmd_dispatch_pkg.sv
// Shared command-word definitions for cmd_dispatch and the per-target handlers:
// field layout, target/instruction codes and the error-response builder.
package cmd_dispatch_pkg;

  typedef struct packed {
    logic [7:0]  target;
    logic [7:0]  instr;
    logic [15:0] arg;
  } cmd_word_t;

  localparam logic [7:0]  C_TARGET_PHF     = 8'h01;
  localparam logic [7:0]  C_PHF_GET_STATUS = 8'h02;
  localparam logic [15:0] C_RSP_ERR        = 16'hEEEE;

  function automatic logic [7:0] cmd_target(input logic [31:0] c);
    cmd_word_t w;
    w = c;
    return w.target;
  endfunction

  function automatic logic [7:0] cmd_instr(input logic [31:0] c);
    cmd_word_t w;
    w = c;
    return w.instr;
  endfunction

  // Error response echoes target/instr so the host can match it to its command.
  function automatic logic [31:0] set_cmd_err(input logic [31:0] c);
    cmd_word_t w;
    w     = c;
    w.arg = C_RSP_ERR;
    return w;
  endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Byte-stream, handler-bus and response-stream signals of cmd_dispatch.
// master: the dispatcher; slave: the byte source/sink and handlers.
interface cmd_dispatch_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] cmd;
  logic        run;
  logic        rsp_rdy;
  logic [31:0] rsp;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rsp_timeouts;

  modport master (
    input  rx_data, rx_valid, rsp_rdy, rsp, tx_ready,
    output rx_ready, cmd, run, tx_data, tx_valid, rsp_timeouts
  );

  modport slave (
    output rx_data, rx_valid, rsp_rdy, rsp, tx_ready,
    input  rx_ready, cmd, run, tx_data, tx_valid, rsp_timeouts
  );
endinterface

// File: rtl/cmd_tx_ser.sv
// Response serializer: loads a 32-bit word and emits it MSB byte first over
// valid/ready; done pulses with the handshake of the 4th byte.
module cmd_tx_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] shift;
  logic [1:0]  cnt;
  logic        valid;

  assign tx_data  = shift[31:24];
  assign tx_valid = valid;
  assign done     = valid && tx_ready && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shift <= word;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (valid && tx_ready) begin
      shift <= {shift[23:0], 8'h00};
      cnt   <= cnt + 2'd1;
      if (cnt == 2'd3)
        valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Command front-end: bytes -> 32-bit cmd + run strobe -> response or timeout
// error -> bytes. Optional partial-command idle timeout: CMD_DISPATCH_RX_TIMEOUT_EN.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 256,
  parameter int unsigned RX_TIMEOUT  = 1024
) (
  input logic          clk,
  input logic          rst_n,
  cmd_dispatch_if.master bus
);

  localparam logic [1:0] S_RX       = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_TX       = 2'd3;

  // One timer serves both the response wait and the rx idle count; the two
  // live in mutually exclusive states, so it is sized for the larger limit.
  localparam int unsigned T_MAX = (RSP_TIMEOUT > RX_TIMEOUT) ? RSP_TIMEOUT : RX_TIMEOUT;
  localparam int unsigned TW    = $clog2(T_MAX);
  localparam logic [TW-1:0] RSP_LIM = TW'(RSP_TIMEOUT - 1);
`ifdef CMD_DISPATCH_RX_TIMEOUT_EN
  localparam logic [TW-1:0] RX_LIM  = TW'(RX_TIMEOUT - 1);
`endif

  logic [1:0]    state;
  logic [1:0]    bcnt;
  logic [31:0]   cmd_q;
  logic [TW-1:0] timer;
  logic [7:0]    to_cnt;
  logic          rx_fire;
  logic          ser_load;
  logic [31:0]   ser_word;
  logic          ser_done;

  assign bus.rx_ready     = rst_n && (state == S_RX);
  assign bus.run          = (state == S_RUN);
  assign bus.cmd          = cmd_q;
  assign bus.rsp_timeouts = to_cnt;

  assign rx_fire  = bus.rx_valid && bus.rx_ready;
  // A response arriving on the limit cycle takes priority over the error word.
  assign ser_load = (state == S_WAIT_RSP) && (bus.rsp_rdy || (timer == RSP_LIM));
  assign ser_word = bus.rsp_rdy ? bus.rsp : set_cmd_err(cmd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RX;
      bcnt   <= '0;
      cmd_q  <= '0;
      timer  <= '0;
      to_cnt <= '0;
    end else begin
      case (state)
        S_RX: begin
          if (rx_fire) begin
            cmd_q <= {cmd_q[23:0], bus.rx_data};
            if (bcnt == 2'd3) begin
              bcnt  <= '0;
              state <= S_RUN;
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end
`ifdef CMD_DISPATCH_RX_TIMEOUT_EN
          if (rx_fire || (bcnt == 2'd0)) begin
            timer <= '0;
          end else if (timer == RX_LIM) begin
            timer <= '0;
            bcnt  <= '0;
            cmd_q <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        S_RUN: begin
          timer <= '0;
          state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (bus.rsp_rdy) begin
            state <= S_TX;
          end else if (timer == RSP_LIM) begin
            if (to_cnt != '1)
              to_cnt <= to_cnt + 8'd1;
            state <= S_TX;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_TX: begin
          if (ser_done)
            state <= S_RX;
        end
      endcase
    end
  end

  cmd_tx_ser u_tx_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .word     (ser_word),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch (RSP_TIMEOUT=8, RX_TIMEOUT=16); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_cmd_dispatch;
  import cmd_dispatch_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cmd_dispatch_if bus ();

  cmd_dispatch #(.RSP_TIMEOUT(8), .RX_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Leaves the bench at the falling edge of the run cycle.
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0]);
    end
  endtask

  task automatic expect_run(input string tag, input logic [31:0] c);
    check_eq({tag, "_run"}, 32'(bus.run), 32'd1);
    check_eq({tag, "_cmd"}, bus.cmd, c);
  endtask

  task automatic wait_quiet(input string tag, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq({tag, "_run_low"}, 32'(bus.run), 32'd0);
      check_eq({tag, "_txv_low"}, 32'(bus.tx_valid), 32'd0);
    end
  endtask

  task automatic respond(input string tag, input int unsigned d, input logic [31:0] v);
    wait_quiet(tag, d);
    bus.rsp_rdy = 1'b1;
    bus.rsp     = v;
    @(negedge clk);
    bus.rsp_rdy = 1'b0;
  endtask

  task automatic recv_word(input string tag, input logic [31:0] w, input bit stall);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic [31:0] t;
    logic        rdy;
    while (idx < 4 && cyc < 64) begin
      t = w >> (8 * (3 - idx));
      check_eq({tag, "_txv"}, 32'(bus.tx_valid), 32'd1);
      check_eq({tag, "_txd"}, 32'(bus.tx_data), 32'(t[7:0]));
      check_eq({tag, "_rxr_low"}, 32'(bus.rx_ready), 32'd0);
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      bus.tx_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    bus.tx_ready = 1'b0;
    check_eq({tag, "_nbytes"}, idx, 32'd4);
    check_eq({tag, "_txv_end"}, 32'(bus.tx_valid), 32'd0);
    check_eq({tag, "_rxr_end"}, 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rxr"}, 32'(bus.rx_ready), 32'd0);
    check_eq({tag, "_run"}, 32'(bus.run), 32'd0);
    check_eq({tag, "_cmd"}, bus.cmd, 32'h0);
    check_eq({tag, "_txv"}, 32'(bus.tx_valid), 32'd0);
    check_eq({tag, "_txd"}, 32'(bus.tx_data), 32'h0);
    check_eq({tag, "_tocnt"}, 32'(bus.rsp_timeouts), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rsp_rdy  = 1'b0;
    bus.rsp      = '0;
    bus.tx_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_rxr", 32'(bus.rx_ready), 32'd1);

    // Basic command, handler answers 2 cycles after run.
    send_word(32'h12345678);
    expect_run("t1", 32'h12345678);
    respond("t1", 2, 32'hCAFEF00D);
    recv_word("t1", 32'hCAFEF00D, 1'b0);

    // PHF get-status, sts=1.
    c = {C_TARGET_PHF, C_PHF_GET_STATUS, 16'h0000};
    send_word(c);
    expect_run("t2", 32'h01020000);
    respond("t2", 2, {c[31:16], 16'h0001});
    recv_word("t2", 32'h01020001, 1'b0);

    // Stalling consumer.
    send_word(32'h0A0B0C0D);
    expect_run("t4", 32'h0A0B0C0D);
    respond("t4", 3, 32'h11223344);
    recv_word("t4", 32'h11223344, 1'b1);

    // Unknown target: no responder, error word after 8 wait cycles; late rsp ignored.
    send_word(32'h7F1055AA);
    expect_run("t3", 32'h7F1055AA);
    wait_quiet("t3", 8);
    @(negedge clk);
    check_eq("t3_tocnt", 32'(bus.rsp_timeouts), 32'd1);
    bus.rsp_rdy = 1'b1;
    bus.rsp     = 32'h99999999;
    recv_word("t3", 32'h7F10EEEE, 1'b0);
    bus.rsp_rdy = 1'b0;
    check_eq("t3_tocnt_after", 32'(bus.rsp_timeouts), 32'd1);

    // Response on the limit cycle wins; counter unchanged.
    send_word(32'h7F2000FF);
    expect_run("tie", 32'h7F2000FF);
    respond("tie", 8, 32'h5A5AA5A5);
    recv_word("tie", 32'h5A5AA5A5, 1'b0);
    check_eq("tie_tocnt", 32'(bus.rsp_timeouts), 32'd1);

    // Partial command followed by a long idle gap.
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (20) @(negedge clk);
    check_eq("t5_rxr_idle", 32'(bus.rx_ready), 32'd1);
`ifdef CMD_DISPATCH_RX_TIMEOUT_EN
    check_eq("t5_cmd_cleared", bus.cmd, 32'h0);
    send_word(32'h11223344);
    expect_run("t5", 32'h11223344);
`else
    check_eq("t5_cmd_partial", bus.cmd & 32'h0000FFFF, 32'h0000AABB);
    send_byte(8'h11);
    send_byte(8'h22);
    expect_run("t5", 32'hAABB1122);
`endif
    respond("t5", 2, 32'h600DC0DE);
    recv_word("t5", 32'h600DC0DE, 1'b0);

    // Reset in the middle of sending a response.
    send_word(32'h01020304);
    expect_run("t6", 32'h01020304);
    respond("t6", 2, 32'hA1B2C3D4);
    check_eq("t6_txd0", 32'(bus.tx_data), 32'h000000A1);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check_eq("t6_txd1", 32'(bus.tx_data), 32'h000000B2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_rxr_rel", 32'(bus.rx_ready), 32'd1);
    check_eq("t6_txv_rel", 32'(bus.tx_valid), 32'd0);
    send_word(32'hDEADBEEF);
    expect_run("t6b", 32'hDEADBEEF);
    respond("t6b", 1, 32'h0BADF00D);
    recv_word("t6b", 32'h0BADF00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
Upstream command front-end for the per-target command handlers (phf_cmds and its siblings).
- Assembles a 32-bit command word from a byte stream, big-endian.
- Presents the word on the shared cmd bus with a one-cycle run strobe, then waits for the aggregated rsp_rdy/rsp from the handlers.
- Substitutes an error response if no handler answers within a timeout, and serializes the 32-bit response back out as bytes.

Parameters:
RSP_TIMEOUT, 256, max cycles spent in S_WAIT_RSP before an error response is generated (>=2).
RX_TIMEOUT, 1024, max idle cycles between bytes of a partial command (used only with CMD_DISPATCH_RX_TIMEOUT_EN).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
rx_data  input  8  incoming command byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  byte accepted when rx_valid && rx_ready
cmd  output  32  command word to handlers; stable from the run cycle until the response is captured
run  output  1  one-cycle strobe, cmd valid
rsp_rdy  input  1  one-cycle pulse from a handler (OR of all handlers)
rsp  input  32  handler response, valid when rsp_rdy
tx_data  output  8  outgoing response byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  consumer accepts byte on tx_valid && tx_ready
rsp_timeouts  output  8  saturating count of response timeouts

Behaviour:
Reset values: fsm=S_RX, cmd=0, run=0, rx_ready=0 (combinational, state-decoded), tx_valid=0, tx_data=0, byte count=0, rsp_timeouts=0.

States:
- S_RX
  - rx_ready=1.
  - Each accepted byte shifts into cmd: cmd <= {cmd[23:0], rx_data}; byte count increments.
  - On the 4th byte: count -> 0, go to S_RUN.
- S_RUN
  - run=1 for exactly this cycle; go to S_WAIT_RSP.
  - Timeout counter cleared.
- S_WAIT_RSP
  - If rsp_rdy: latch rsp into the tx shift register, go to S_TX.
  - Else if counter == RSP_TIMEOUT-1: latch SET_CMD_ERR(cmd) (macro from cmd_defs.vh), increment rsp_timeouts (saturating at 255), go to S_TX.
  - Otherwise counter+1.
- S_TX
  - tx_valid=1, tx_data = shift[31:24].
  - On tx_ready: shift left 8 bits; after the 4th accepted byte, tx_valid=0 and go to S_RX.
  - tx_data holds while tx_ready=0.

Rules and boundary conditions:
- rx_ready is 0 outside S_RX. Bytes are not accepted or lost; the sender must hold them.
- rsp_rdy outside S_WAIT_RSP is ignored, including a late response after a timeout.
- rsp_rdy in the same cycle the counter reaches the limit: the real response wins, and rsp_timeouts is unchanged.
- run is never asserted while a response is outstanding. At most one command is in flight.
- Latency:
  - 4th rx byte accepted at cycle N -> run at N+1.
  - A handler with registered rsp_rdy at N+3 -> tx_valid at N+4.
- An unknown target means no handler answers, which yields the timeout error response.
- Reset mid-operation returns everything to reset values immediately; a partial command or response is discarded.

Optional Feature:
CMD_DISPATCH_RX_TIMEOUT_EN
- Defined:
  - In S_RX with byte count 1..3, an idle counter increments on every cycle without an accepted byte and clears on each accepted byte.
  - Reaching RX_TIMEOUT-1 clears the byte count and cmd to 0, discarding the partial command. No response is sent.
- Undefined: no idle counter; a partial command waits indefinitely.

Decomposition:
- Shared cmd_defs.vh: CMD_TARGET/CMD_INSTR field macros, SET_CMD_ERR, target codes.
- Local localparams: state encodings.
- One natural sub-module, cmd_tx_ser: 32-bit load, 4-byte valid/ready serializer with a done pulse.

Test Plan:
1. Bytes 0x12,0x34,0x56,0x78 with a stub handler pulsing rsp_rdy, rsp=0xCAFEF00D, 2 cycles after run -> cmd=0x12345678 with a single run pulse; tx bytes 0xCA,0xFE,0xF0,0x0D.
2. Command to phf_cmds with target C_TARGET_PHF, instr C_PHF_GET_STATUS, sts=1 -> tx word {cmd[31:16],16'h0001}, tx_valid 3 cycles after run.
3. No responder, RSP_TIMEOUT=8 -> error word SET_CMD_ERR(cmd) exactly 8 cycles after entering S_WAIT_RSP; rsp_timeouts=1; a late rsp_rdy is ignored.
4. tx_ready toggling 1,0,0,1,... -> tx_data holds while stalled; rx_ready=0 throughout; no byte is dropped or duplicated.
5. With the macro defined and RX_TIMEOUT=16: send 2 bytes, idle 20 cycles, then send 4 new bytes -> cmd equals the new 4 bytes only. Without the macro, the first 2 bytes prefix the cmd.
6. Assert rst_n low during S_TX -> tx_valid=0, rx_ready=1 on the cycle after release, and the next command is processed normally.
